// File: rtl/writeback_buffer.sv
// Result capture FIFO between the arithmetic pipeline and the common data bus.
// Absorbs every valid result (the pipeline cannot be stalled) and stalls issue early enough to never drop one.
module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [4:0]       in_rob_entry,
    input  logic [4:0]       in_dest_reg,
    input  logic [4:0]       in_flag_reg,
    input  logic [7:0]       in_result_val,
    input  logic [7:0]       in_result_flags,
    input  logic [7:0]       in_arch_dest_regs,
    input  logic             flush,
    input  logic             cdb_grant,
    output logic             cdb_valid,
    output logic [4:0]       cdb_rob_entry,
    output logic [4:0]       cdb_dest_reg,
    output logic [4:0]       cdb_flag_reg,
    output logic [7:0]       cdb_result_val,
    output logic [7:0]       cdb_result_flags,
    output logic [7:0]       cdb_arch_dest_regs,
    output logic             issue_stall,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    typedef struct packed {
        logic [4:0] rob_entry;
        logic [4:0] dest_reg;
        logic [4:0] flag_reg;
        logic [7:0] result_val;
        logic [7:0] result_flags;
        logic [7:0] arch_dest_regs;
    } wb_entry_t;

    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] STALL_CNT = (PTR_W+1)'(DEPTH - 1);

    wb_entry_t [DEPTH-1:0] mem;
    wb_entry_t             in_entry;
    wb_entry_t             head;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  pop;
    logic                  push;

    assign in_entry = '{rob_entry:      in_rob_entry,
                        dest_reg:       in_dest_reg,
                        flag_reg:       in_flag_reg,
                        result_val:     in_result_val,
                        result_flags:   in_result_flags,
                        arch_dest_regs: in_arch_dest_regs};

    assign full      = (count == FULL_CNT);
    assign cdb_valid = (count != '0);
    assign pop       = cdb_valid && cdb_grant;
    // A push into a full buffer is still legal when the head leaves the same cycle.
    assign push      = in_valid && (!full || pop);

    // One entry of slack covers the result already inside the one-stage pipeline.
    assign issue_stall = (count >= STALL_CNT);

    assign head               = mem[rd_ptr];
    assign cdb_rob_entry      = head.rob_entry;
    assign cdb_dest_reg       = head.dest_reg;
    assign cdb_flag_reg       = head.flag_reg;
    assign cdb_result_val     = head.result_val;
    assign cdb_result_flags   = head.result_flags;
    assign cdb_arch_dest_regs = head.arch_dest_regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky until reset; flush leaves the error visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (!flush && in_valid && full && !pop)
            overflow <= 1'b1;
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: queue-based reference model compared every cycle,
// plus hand-computed literal checks at key points of each scenario.
module tb_writeback_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [4:0]       in_rob_entry, in_dest_reg, in_flag_reg;
    logic [7:0]       in_result_val, in_result_flags, in_arch_dest_regs;
    logic             flush;
    logic             cdb_grant;
    logic             cdb_valid;
    logic [4:0]       cdb_rob_entry, cdb_dest_reg, cdb_flag_reg;
    logic [7:0]       cdb_result_val, cdb_result_flags, cdb_arch_dest_regs;
    logic             issue_stall;
    logic [PTR_W:0]   count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    writeback_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_rob_entry(in_rob_entry), .in_dest_reg(in_dest_reg),
        .in_flag_reg(in_flag_reg), .in_result_val(in_result_val),
        .in_result_flags(in_result_flags), .in_arch_dest_regs(in_arch_dest_regs),
        .flush(flush), .cdb_grant(cdb_grant),
        .cdb_valid(cdb_valid), .cdb_rob_entry(cdb_rob_entry), .cdb_dest_reg(cdb_dest_reg),
        .cdb_flag_reg(cdb_flag_reg), .cdb_result_val(cdb_result_val),
        .cdb_result_flags(cdb_result_flags), .cdb_arch_dest_regs(cdb_arch_dest_regs),
        .issue_stall(issue_stall), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry layout used by both model and checks: {rob, dest, flag, val, flags, arch}.
    function automatic logic [38:0] mk(input logic [4:0] rob, input logic [4:0] dst,
                                       input logic [4:0] flg, input logic [7:0] val,
                                       input logic [7:0] fl, input logic [7:0] arch);
        return {rob, dst, flg, val, fl, arch};
    endfunction

    logic [38:0] dut_head;
    assign dut_head = {cdb_rob_entry, cdb_dest_reg, cdb_flag_reg,
                       cdb_result_val, cdb_result_flags, cdb_arch_dest_regs};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of results and a sticky drop flag.
    logic [38:0] mq[$];
    logic        m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (flush) begin
            mq.delete();
        end else begin
            automatic bit was_full = (mq.size() == DEPTH);
            automatic bit do_pop   = (mq.size() != 0) && cdb_grant;
            if (do_pop) void'(mq.pop_front());
            if (in_valid) begin
                if (!was_full || do_pop)
                    mq.push_back({in_rob_entry, in_dest_reg, in_flag_reg,
                                  in_result_val, in_result_flags, in_arch_dest_regs});
                else
                    m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", 64'(cdb_valid), 64'(mq.size() != 0));
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_stall", 64'(issue_stall), 64'(mq.size() >= DEPTH - 1));
            chk("m_ovf", 64'(overflow), 64'(m_ovf));
            if (mq.size() != 0) chk("m_head", 64'(dut_head), 64'(mq[0]));
        end
    end

    task automatic drive(input logic v, input logic [38:0] e, input logic g, input logic f);
        in_valid = v;
        {in_rob_entry, in_dest_reg, in_flag_reg,
         in_result_val, in_result_flags, in_arch_dest_regs} = e;
        cdb_grant = g;
        flush     = f;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cdb_grant = 1'b0;
        flush     = 1'b0;
    endtask

    function automatic logic [38:0] v8(input logic [7:0] val);
        return mk(5'(val[3:0]), 5'd1, 5'd2, val, ~val, 8'h0F);
    endfunction

    initial begin
        rst_n = 1'b0;
        in_valid = 0; flush = 0; cdb_grant = 0;
        {in_rob_entry, in_dest_reg, in_flag_reg,
         in_result_val, in_result_flags, in_arch_dest_regs} = '0;
        #3;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_stall", 64'(issue_stall), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_fields", 64'(dut_head), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass-through
        drive(1, mk(5'd3, 5'd7, 5'd9, 8'h5A, 8'h82, 8'h01), 1, 0);
        chk("pt_valid", 64'(cdb_valid), 64'd1);
        chk("pt_fields", 64'(dut_head), 64'(mk(5'd3, 5'd7, 5'd9, 8'h5A, 8'h82, 8'h01)));
        drive(0, '0, 1, 0);
        chk("pt_count", 64'(count), 64'd0);

        // Fill, then full with simultaneous push/pop, then overflow
        drive(1, v8(8'h11), 0, 0);
        drive(1, v8(8'h22), 0, 0);
        chk("fill2_stall", 64'(issue_stall), 64'd0);
        drive(1, v8(8'h33), 0, 0);
        chk("fill3_stall", 64'(issue_stall), 64'd1);
        drive(1, v8(8'h44), 0, 0);
        chk("fill4_count", 64'(count), 64'd4);
        chk("fill4_head", 64'(cdb_result_val), 64'h11);
        drive(1, v8(8'h55), 1, 0);
        chk("pp_count", 64'(count), 64'd4);
        chk("pp_ovf", 64'(overflow), 64'd0);
        chk("pp_head", 64'(cdb_result_val), 64'h22);
        drive(1, v8(8'h66), 0, 0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd4);
        chk("ovf_head", 64'(dut_head), 64'(v8(8'h22)));
        begin
            logic [7:0] exp_seq [4];
            exp_seq = '{8'h22, 8'h33, 8'h44, 8'h55};
            for (int i = 0; i < 4; i++) begin
                chk("drain_order", 64'(cdb_result_val), 64'(exp_seq[i]));
                drive(0, '0, 1, 0);
            end
        end
        chk("drain_empty", 64'(cdb_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        drive(0, '0, 1, 0);
        chk("grant_empty", 64'(count), 64'd0);

        // Flush with push and grant in the same cycle
        drive(1, v8(8'hA1), 0, 0);
        drive(1, v8(8'hA2), 0, 0);
        chk("fl_pre", 64'(count), 64'd2);
        drive(1, v8(8'h99), 1, 1);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'(cdb_valid), 64'd0);
        chk("fl_ovf", 64'(overflow), 64'd1);
        drive(1, v8(8'h77), 0, 0);
        chk("post_fl_val", 64'(cdb_result_val), 64'h77);
        chk("post_fl_count", 64'(count), 64'd1);

        // Mixed traffic honouring issue_stall; model checks every cycle
        for (int i = 0; i < 40; i++)
            drive((i % 3 != 2) && !issue_stall, v8(8'(i * 7 + 3)), (i % 4) != 1, 0);

        // Asynchronous reset mid-cycle
        drive(1, v8(8'hBE), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(cdb_valid), 64'd0);
        chk("arst_ovf", 64'(overflow), 64'd0);
        chk("arst_fields", 64'(dut_head), 64'd0);
        rst_n = 1'b1;
        drive(1, v8(8'hC3), 0, 0);
        chk("arst_push", 64'(cdb_result_val), 64'hC3);
        repeat (3) drive(0, '0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Consumer end of the arithmetic pipeline result interface. The pipeline has no backpressure, so this block captures every valid result into a small FIFO.
- It presents the oldest buffered result to the common data bus (CDB) using a valid/grant handshake.
- It drives an issue stall so the issue stage never sends the pipeline more results than the FIFO can hold.

Parameters:
- DEPTH, 4, number of result entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  result valid from the arithmetic pipeline (output_valid).
- in_rob_entry  input  5  ROB entry of the result.
- in_dest_reg  input  5  physical destination register.
- in_flag_reg  input  5  physical flag register.
- in_result_val  input  8  result value.
- in_result_flags  input  8  result flags.
- in_arch_dest_regs  input  8  architectural destination mask.
- flush  input  1  synchronous pipeline flush (mispredict or exception).
- cdb_grant  input  1  CDB arbiter accepts the current head this cycle.
- cdb_valid  output  1  head entry is valid.
- cdb_rob_entry  output  5  head field.
- cdb_dest_reg  output  5  head field.
- cdb_flag_reg  output  5  head field.
- cdb_result_val  output  8  head field.
- cdb_result_flags  output  8  head field.
- cdb_arch_dest_regs  output  8  head field.
- issue_stall  output  1  issue stage must not dispatch to the pipeline.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky error: a result was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count are 0; overflow is 0.
  - cdb_valid is 0. All cdb_* data outputs are 0 (entry storage cleared).
  - issue_stall is 0.
- Storage is circular: wr_ptr and rd_ptr are PTR_W bits wide and wrap from DEPTH-1 to 0.
- cdb_valid = (count != 0). The cdb_* fields are driven combinationally from storage[rd_ptr]. They hold stable while cdb_valid is high and cdb_grant is low.
- Pop occurs when cdb_valid && cdb_grant. rd_ptr increments. cdb_grant while empty is ignored.
- Push occurs when in_valid && (count < DEPTH || pop). All six fields are written to storage[wr_ptr] and wr_ptr increments.
- Latency:
  - A result pushed into an empty buffer appears on cdb_valid the next cycle.
  - There is no combinational in-to-cdb bypass.
- FIFO order is strict. Results leave in arrival order.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Both: unchanged.
- Full with simultaneous push and pop: both take effect; count stays DEPTH.
- Full with push and no pop:
  - The input is dropped and overflow sets; it clears only on reset.
  - This is a protocol violation and must be unreachable when issue_stall is honoured.
- issue_stall = (count >= DEPTH-1), registered-free (combinational from count).
  - This leaves one entry of slack for the result already in flight in the one-stage pipeline.
- Flush has priority over push and pop:
  - Next cycle, count, wr_ptr and rd_ptr are 0 and cdb_valid is 0.
  - An in_valid result in the flush cycle is discarded.
  - A grant in the flush cycle is ignored; the head is not counted as popped.
  - overflow is unchanged.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Test Plan:
- Reset: drive rst_n=0 with no clk edges, then release. Required: cdb_valid=0, count=0, issue_stall=0, overflow=0, all cdb_* fields 0.
- Single pass-through: push {rob=3, dest=7, flag=9, val=0x5A, flags=0x82, arch=0x01} with cdb_grant=1. Required: cdb_valid=1 the next cycle with those exact fields; count returns to 0 one cycle later.
- Ordering and backpressure:
  - Push vals 0x11, 0x22, 0x33, 0x44 on consecutive cycles with grant=0.
  - Required: count reaches 4; issue_stall=1 once count=3.
  - Then hold grant=1. Required: pops 0x11, 0x22, 0x33, 0x44 in order, wrapping rd_ptr.
- Full with simultaneous push and pop: at count=4, in_valid with val=0x55 and grant=1. Required: head 0x11 leaves, count stays 4, overflow=0, and 0x55 emerges last.
- Overflow: at count=4, in_valid with grant=0. Required: overflow=1 and sticky, count stays 4, stored data unchanged.
- Flush: at count=2, assert flush together with in_valid and grant. Required: next cycle count=0, cdb_valid=0, in-flight result absent; a subsequent push of 0x77 appears normally.
